coreaxi4dmacontroller_ram_rd_streamer: RTL

Read-side controller for the DMA controller's 32-bit dual-port RAM1K20 buffer stores. It owns the write and read pointers, gates writer strobes against fullness, and issues RAM reads. It absorbs the RAM's 1- or 2-cycle read latency in a 3-entry output buffer and presents the stored words, in order, on a valid/ready stream to the downstream DMA datapath. It sits between the buffer-RAM wrapper and the consumer, and provides the drain end of the buffer.

---
 rtl/coreaxi4dmacontroller_pkg.sv | 12 +
 rtl/coreaxi4dmacontroller_obuf3.sv | 70 +++++++
 rtl/coreaxi4dmacontroller_ram_rd_streamer.sv | 109 ++++++++++
 3 files changed

// File: rtl/coreaxi4dmacontroller_pkg.sv
// Shared constants for the DMA buffer-RAM read streamer: data width, output
// buffer depth and the RAM read latency selected by the output-register option.
package coreaxi4dmacontroller_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int OBUF_DEPTH = 3;

    function automatic int rd_latency(input int pipeline);
        return (pipeline != 0) ? 2 : 1;
    endfunction

endpackage

// File: rtl/coreaxi4dmacontroller_obuf3.sv
// 3-entry registered FIFO holding RAM returns; head visible the cycle after push.
// Pop only when non-empty; push when full is dropped unless a pop frees the slot.
module coreaxi4dmacontroller_obuf3
    import coreaxi4dmacontroller_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  clr_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_dat_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_dat_o,
    output logic                  vld_o,
    output logic [1:0]            cnt_o
);

    logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
    logic [1:0]            rd_idx_q;
    logic [1:0]            wr_idx_q;
    logic [1:0]            cnt_q;
    logic [1:0]            cnt_d;
    logic                  pop_ok;
    logic                  push_ok;

    function automatic logic [1:0] idx_inc(input logic [1:0] idx);
        return (idx == 2'(OBUF_DEPTH - 1)) ? 2'd0 : idx + 2'd1;
    endfunction

    assign pop_ok  = pop_i & (cnt_q != 2'd0);
    assign push_ok = push_i & ((cnt_q != 2'(OBUF_DEPTH)) | pop_ok);

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop_ok})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_idx_q <= 2'd0;
            wr_idx_q <= 2'd0;
            cnt_q    <= 2'd0;
        end else if (clr_i) begin
            // Storage is left as-is; only the bookkeeping defines what is valid.
            rd_idx_q <= 2'd0;
            wr_idx_q <= 2'd0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_idx_q] <= push_dat_i;
                wr_idx_q        <= idx_inc(wr_idx_q);
            end
            if (pop_ok) begin
                rd_idx_q <= idx_inc(rd_idx_q);
            end
            cnt_q <= cnt_d;
        end
    end

    assign head_dat_o = mem_q[rd_idx_q];
    assign vld_o      = (cnt_q != 2'd0);
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/coreaxi4dmacontroller_ram_rd_streamer.sv
// Buffer-RAM pointer owner and read streamer; write-to-RD_VALID is L+2 cycles.
// Reads issue only when the 3-entry output buffer can absorb every in-flight return.
module coreaxi4dmacontroller_ram_rd_streamer
    import coreaxi4dmacontroller_pkg::*;
#(
    parameter int ADDR_WIDTH = 2,
    parameter int PIPELINE   = 1
) (
    input  logic                  CLOCK,
    input  logic                  RESETN,
    input  logic                  FLUSH,
    input  logic                  WR_EN,
    output logic [ADDR_WIDTH-1:0] WR_ADDR,
    output logic                  RAM_WR_EN,
    output logic                  WR_FULL,
    output logic [ADDR_WIDTH-1:0] RAM_RD_ADDR,
    output logic                  RAM_RD_EN,
    input  logic [DATA_WIDTH-1:0] RAM_RD_DATA,
    output logic                  RD_VALID,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    input  logic                  RD_READY,
    output logic [ADDR_WIDTH:0]   LEVEL
);

    localparam int            LAT     = rd_latency(PIPELINE);
    localparam int            PW      = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] DEPTH_C = PW'(2 ** ADDR_WIDTH);

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LAT-1:0] inflight_q, inflight_d;
    logic [PW-1:0]  level;
    logic           full;
    logic           wr_acc;
    logic           rd_iss;
    logic           rd_room;
    logic           obuf_pop;
    logic           obuf_vld;
    logic [1:0]     obuf_cnt;
    logic [2:0]     occ;

    assign level  = wr_ptr_q - rd_ptr_q;
    assign full   = (level == DEPTH_C);
    // RESETN gates the write strobe so the RAM sees no write while held in reset.
    assign wr_acc = WR_EN & ~full & ~FLUSH & RESETN;

    // Words already committed to the output buffer: queued plus still returning.
    always_comb begin
        occ = {1'b0, obuf_cnt};
        for (int i = 0; i < LAT; i++) begin
            occ = occ + {2'b00, inflight_q[i]};
        end
    end

    assign obuf_pop = obuf_vld & RD_READY;
    assign rd_room  = (occ < (3'(OBUF_DEPTH) + {2'b00, obuf_pop}));
    assign rd_iss   = (level != '0) & rd_room & ~FLUSH;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = '0;
        if (!FLUSH) begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (rd_iss) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            inflight_d[0] = rd_iss;
            for (int i = 1; i < LAT; i++) begin
                inflight_d[i] = inflight_q[i-1];
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    coreaxi4dmacontroller_obuf3 u_obuf (
        .clk_i      (CLOCK),
        .rst_n_i    (RESETN),
        .clr_i      (FLUSH),
        .push_i     (inflight_q[LAT-1]),
        .push_dat_i (RAM_RD_DATA),
        .pop_i      (obuf_pop),
        .head_dat_o (RD_DATA),
        .vld_o      (obuf_vld),
        .cnt_o      (obuf_cnt)
    );

    assign WR_ADDR     = wr_ptr_q[ADDR_WIDTH-1:0];
    assign RAM_RD_ADDR = rd_ptr_q[ADDR_WIDTH-1:0];
    assign RAM_WR_EN   = wr_acc;
    assign RAM_RD_EN   = rd_iss;
    assign WR_FULL     = full;
    assign RD_VALID    = obuf_vld;
    assign LEVEL       = level;

endmodule
